// File: rtl/seq_mul_param.sv
// Sequential shift-and-add multiplier: operands A then B arrive on one valid/ready bus,
// unsigned or two's-complement signed, full 2*WIDTH-bit product after WIDTH iterations.
module seq_mul_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_mode;
  logic            r_neg;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic            w_hs;
  logic [PW-1:0]   w_acc_next;

  // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_mag(input logic is_signed, input logic [WIDTH-1:0] x);
    if (is_signed && x[WIDTH-1]) return ~x + WIDTH'(1);
    return x;
  endfunction

  function automatic logic [PW-1:0] f_apply_sign(input logic neg, input logic [PW-1:0] x);
    if (neg) return ~x + PW'(1);
    return x;
  endfunction

  assign w_hs       = data_valid & r_ready;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_neg     <= 1'b0;
      r_a       <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode  <= signed_mode;
            r_state <= S_LOAD_A;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (w_hs) begin
            r_a     <= data_in;
            r_state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_hs) begin
            r_mcand  <= {{WIDTH{1'b0}}, f_mag(r_mode, r_a)};
            r_mplier <= f_mag(r_mode, data_in);
            r_neg    <= r_mode & (r_a[WIDTH-1] ^ data_in[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_ready  <= 1'b0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_product <= f_apply_sign(r_neg, w_acc_next);
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
